ddr_cmd_sched: RTL and testbench
================================

Name: ddr_cmd_sched

Overview:
Parametrised DDR-style command scheduler for the simple_ddr bench. It accepts read and write requests into an in-order request FIFO and runs a power-up boot delay. After boot it pops requests one at a time and drives a split, non-tristate memory interface with burst data beats. Read data beats are collected into a single response. The block sits between the bench traffic generator and the DRAM behavioural model.

Parameters:
DATA_W, 64, width of one data beat on DQ
ADDR_W, 32, request/command address width
DEPTH, 8, request FIFO entries (power of 2, >=2)
BURST, 2, data beats per access (>=1)
RD_LAT, 2, cycles from read command to first read beat (>=1)
BOOT_CYCLES, 16, cycles spent in BOOT after reset (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  FIFO can accept (= !full)
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W*BURST  write data; beat 0 in LSBs
rsp_valid  out  1  one-cycle pulse, read data complete
rsp_addr  out  ADDR_W  address of completed read
rsp_rdata  out  DATA_W*BURST  read data; beat 0 in LSBs
boot_done  out  1  high once FSM has left BOOT
fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy
mem_cmd_valid  out  1  command strobe, one cycle
mem_cmd_we  out  1  command type
mem_cmd_addr  out  ADDR_W  command address
mem_dq_out  out  DATA_W  write beat
mem_dq_oe  out  1  write beat valid / drive enable
mem_dqs_out  out  1  write strobe, toggles once per driven beat
mem_dq_in  in  DATA_W  read beat from memory

Behaviour:
- Reset (rst=0, async): FIFO flushed and fifo_level=0. FSM goes to RESET. All outputs are 0 (req_ready=0 while rst=0). Any in-flight access is dropped with no response.
- FIFO accept:
  - Push on req_valid&&req_ready, in any FSM state, including BOOT.
  - req_ready = (fifo_level<DEPTH) after rst releases.
  - A push while full is not allowed, even if a pop occurs in the same cycle.
  - Simultaneous push+pop leaves fifo_level unchanged.
  - Pointers wrap modulo DEPTH.
- A pushed entry is visible to the FSM one cycle after acceptance.
- FSM states: RESET, BOOT, IDLE, WRITE, WRITE_2, READ, READ_2, RESP.
- RESET -> BOOT after 1 cycle.
- BOOT counts BOOT_CYCLES cycles, then goes to IDLE. boot_done=1 from the first IDLE cycle until the next reset.
- IDLE with FIFO non-empty: pop the head and go to WRITE if we=1, otherwise READ. The pop happens on this transition.
- WRITE (1 cycle): mem_cmd_valid=1, mem_cmd_we=1, mem_cmd_addr=entry addr. Next state is WRITE_2.
- WRITE_2 (BURST cycles):
  - mem_dq_oe=1 and mem_dq_out = beat i, for i = 0..BURST-1.
  - mem_dqs_out toggles on each beat cycle, starting from the level left by the previous write; level is 0 after reset.
  - Next state is IDLE.
- READ (1 cycle, cycle c): mem_cmd_valid=1, mem_cmd_we=0. Next state is READ_2.
- READ_2: sample mem_dq_in at cycles c+RD_LAT .. c+RD_LAT+BURST-1 into beats 0..BURST-1. Then go to RESP.
- RESP (cycle c+RD_LAT+BURST):
  - rsp_valid=1 for exactly this cycle; there is no backpressure.
  - rsp_addr and rsp_rdata hold until the next RESP.
  - Next state is IDLE.
- Outside their active states, mem_cmd_valid, mem_dq_oe and rsp_valid are 0. mem_cmd_addr, mem_cmd_we, mem_dq_out and mem_dqs_out hold their last values.
- Request to command latency from acceptance at edge 0: IDLE sees the entry in cycle 1, and mem_cmd_valid is asserted in cycle 2.
- Ordering is strictly FIFO; there is no reordering and no overlap of accesses.
- Next command issues at the earliest 1 IDLE cycle after WRITE_2 or RESP ends.

Test Plan:
- Boot, defaults: release rst at cycle 0 -> boot_done rises at cycle 1+BOOT_CYCLES=17; no mem_cmd_valid before that; a request accepted during BOOT issues at the first IDLE+1.
- Single write after boot (addr=0x100, wdata={64'hB,64'hA}) -> mem_cmd_valid 1 cycle with we=1, addr=0x100. Then 2 cycles of mem_dq_oe=1 carrying 0xA then 0xB, with mem_dqs_out 0->1->0.
- Single read (addr=0x200), model drives 0x11 at c+2 and 0x22 at c+3 -> rsp_valid pulse at c+4 with rsp_addr=0x200 and rsp_rdata={64'h22,64'h11}.
- Fill 8 requests during BOOT -> fifo_level=8, req_ready=0. A 9th req_valid is not accepted. After the first pop, req_ready=1 the next cycle.
- Interleaved W,R,W,R to the same addresses with the model as memory -> commands issued in order. Each read returns the data of the preceding write; no overlapping mem_dq_oe and read capture windows.
- Assert rst in READ_2 mid-burst -> outputs 0 immediately and fifo_level=0. No rsp_valid; after re-release, a full BOOT is repeated.

Source files
------------

// File: rtl/ddr_cmd_sched_if.sv
// Request/response and memory-side signal bundle for ddr_cmd_sched.
// slave is the scheduler; master is the traffic/DRAM side.
interface ddr_cmd_sched_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  parameter int BURST  = 2
);
  localparam int LW = $clog2(DEPTH + 1);

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [ADDR_W-1:0]         req_addr;
  logic [DATA_W*BURST-1:0]   req_wdata;
  logic                      rsp_valid;
  logic [ADDR_W-1:0]         rsp_addr;
  logic [DATA_W*BURST-1:0]   rsp_rdata;
  logic                      boot_done;
  logic [LW-1:0]             fifo_level;
  logic                      mem_cmd_valid;
  logic                      mem_cmd_we;
  logic [ADDR_W-1:0]         mem_cmd_addr;
  logic [DATA_W-1:0]         mem_dq_out;
  logic                      mem_dq_oe;
  logic                      mem_dqs_out;
  logic [DATA_W-1:0]         mem_dq_in;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_dq_in,
    input  req_ready, rsp_valid, rsp_addr, rsp_rdata, boot_done,
    input  fifo_level, mem_cmd_valid, mem_cmd_we, mem_cmd_addr,
    input  mem_dq_out, mem_dq_oe, mem_dqs_out
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_dq_in,
    output req_ready, rsp_valid, rsp_addr, rsp_rdata, boot_done,
    output fifo_level, mem_cmd_valid, mem_cmd_we, mem_cmd_addr,
    output mem_dq_out, mem_dq_oe, mem_dqs_out
  );
endinterface

// File: rtl/ddr_cmd_sched.sv
// In-order DDR command scheduler: request FIFO, boot delay,
// one access at a time with burst write beats and read capture.
module ddr_cmd_sched #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 8,
  parameter int BURST       = 2,
  parameter int RD_LAT      = 2,
  parameter int BOOT_CYCLES = 16
) (
  input logic           clk,
  input logic           rst,
  ddr_cmd_sched_if.slave bus
);
  localparam int BW   = DATA_W * BURST;
  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = $clog2(DEPTH + 1);
  localparam int CMAX = (BOOT_CYCLES > RD_LAT + BURST) ?
                        BOOT_CYCLES : RD_LAT + BURST;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_RESET, S_BOOT, S_IDLE, S_WRITE,
    S_WRITE_2, S_READ, S_READ_2, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic              boot_done_q, boot_done_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [BW-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0] dq_q, dq_d;
  logic              dqs_q, dqs_d;
  logic [BW-1:0]     rd_buf_q, rd_buf_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [BW-1:0]     rsp_data_q, rsp_data_d;
  logic              push, pop, ready;

  logic              f_we_q   [DEPTH];
  logic [ADDR_W-1:0] f_addr_q [DEPTH];
  logic [BW-1:0]     f_data_q [DEPTH];

  assign ready = rst && (lvl_q < LW'(DEPTH));
  assign push  = bus.req_valid && ready;

  // FIFO storage; occupancy is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (push) begin
      f_we_q[wr_ptr_q]   <= bus.req_we;
      f_addr_q[wr_ptr_q] <= bus.req_addr;
      f_data_q[wr_ptr_q] <= bus.req_wdata;
    end
  end

  // FIFO pointer and level update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) lvl_d = lvl_q + 1'b1;
    if (!push && pop) lvl_d = lvl_q - 1'b1;
  end

  // Sequencer: boot, pop, command, burst beats, read capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    boot_done_d = boot_done_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    wdata_d     = wdata_q;
    dq_d        = dq_q;
    dqs_d       = dqs_q;
    rd_buf_d    = rd_buf_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    pop         = 1'b0;
    unique case (state_q)
      S_RESET: begin
        state_d = S_BOOT;
        cnt_d   = '0;
      end
      S_BOOT: begin
        if (cnt_q == CW'(BOOT_CYCLES - 1)) begin
          state_d     = S_IDLE;
          boot_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (lvl_q != '0) begin
          pop        = 1'b1;
          cmd_we_d   = f_we_q[rd_ptr_q];
          cmd_addr_d = f_addr_q[rd_ptr_q];
          wdata_d    = f_data_q[rd_ptr_q];
          state_d    = f_we_q[rd_ptr_q] ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        state_d = S_WRITE_2;
        cnt_d   = '0;
        dq_d    = wdata_q[DATA_W-1:0];
        dqs_d   = ~dqs_q;
      end
      S_WRITE_2: begin
        if (cnt_q == CW'(BURST - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          dq_d  = wdata_q[(int'(cnt_q) + 1) * DATA_W +: DATA_W];
          dqs_d = ~dqs_q;
        end
      end
      S_READ: begin
        state_d = S_READ_2;
        cnt_d   = '0;
      end
      S_READ_2: begin
        cnt_d = cnt_q + 1'b1;
        if (int'(cnt_q) >= RD_LAT - 1)
          rd_buf_d[(int'(cnt_q) - RD_LAT + 1) * DATA_W +: DATA_W] =
            bus.mem_dq_in;
        if (cnt_q == CW'(RD_LAT + BURST - 2)) begin
          state_d    = S_RESP;
          rsp_addr_d = cmd_addr_q;
          rsp_data_d = rd_buf_d;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_RESET;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RESET;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      lvl_q       <= '0;
      boot_done_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      wdata_q     <= '0;
      dq_q        <= '0;
      dqs_q       <= 1'b0;
      rd_buf_q    <= '0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      lvl_q       <= lvl_d;
      boot_done_q <= boot_done_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      wdata_q     <= wdata_d;
      dq_q        <= dq_d;
      dqs_q       <= dqs_d;
      rd_buf_q    <= rd_buf_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.req_ready     = ready;
  assign bus.fifo_level    = lvl_q;
  assign bus.boot_done     = boot_done_q;
  assign bus.mem_cmd_valid = (state_q == S_WRITE) || (state_q == S_READ);
  assign bus.mem_cmd_we    = cmd_we_q;
  assign bus.mem_cmd_addr  = cmd_addr_q;
  assign bus.mem_dq_out    = dq_q;
  assign bus.mem_dq_oe     = (state_q == S_WRITE_2);
  assign bus.mem_dqs_out   = dqs_q;
  assign bus.rsp_valid     = (state_q == S_RESP);
  assign bus.rsp_addr      = rsp_addr_q;
  assign bus.rsp_rdata     = rsp_data_q;
endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Random traffic bench for ddr_cmd_sched with a DRAM model
// and a request-order shadow memory as reference.
module tb_ddr_cmd_sched;
  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int DEPTH = 8;
  localparam int BURST = 2;
  localparam int RDL   = 2;
  localparam int BOOT  = 16;
  localparam int BW    = DW * BURST;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    logic [31:0]   acc;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ddr_cmd_sched_if #(.DATA_W(DW), .ADDR_W(AW),
                     .DEPTH(DEPTH), .BURST(BURST)) bus ();

  ddr_cmd_sched #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .BURST(BURST), .RD_LAT(RDL), .BOOT_CYCLES(BOOT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_acc, n_cmd, min_next;
  ent_t q[$];
  logic [BW-1:0] dram   [logic [AW-1:0]];
  logic [BW-1:0] shadow [logic [AW-1:0]];
  logic wr_act, rd_act, exp_dqs;
  int wr_start, rd_start, rd_due;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [BW-1:0] wr_exp, wbuf, rd_exp, rd_mem;
  ent_t e;
  logic in_w, in_r, in_p;
  int bi;

  task automatic chk(input string tag, input logic [BW-1:0] got,
                     input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] dflt(input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'h5a5a5a5a, a + 32'h1234};
  endfunction

  always @(posedge clk) cyc++;

  // Reference model and DRAM model, sampled mid-cycle
  always @(negedge clk) if (rst) begin
    chk("boot_done", bus.boot_done, cyc >= 1 + BOOT);
    if (bus.mem_cmd_valid) begin
      if (q.size() == 0) begin
        chk("cmd_unexp", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        n_cmd++;
        chk("cmd_cyc", cyc,
            (min_next > int'(e.acc) + 2) ? min_next : int'(e.acc) + 2);
        chk("cmd_we", bus.mem_cmd_we, e.we);
        chk("cmd_addr", bus.mem_cmd_addr, e.addr);
        if (e.we) begin
          wr_act = 1'b1; wr_start = cyc + 1;
          wr_addr = e.addr; wr_exp = e.data;
          min_next = cyc + BURST + 2;
        end else begin
          rd_act = 1'b1; rd_start = cyc + RDL;
          rd_due = cyc + RDL + BURST;
          rd_addr = e.addr; rd_exp = e.data;
          rd_mem = dram.exists(e.addr) ? dram[e.addr] : dflt(e.addr);
          min_next = rd_due + 2;
        end
      end
    end
    in_w = wr_act && cyc >= wr_start && cyc < wr_start + BURST;
    if (bus.mem_dq_oe || in_w) chk("dq_oe", bus.mem_dq_oe, in_w);
    if (in_w) begin
      bi = cyc - wr_start;
      chk("dq_beat", bus.mem_dq_out, wr_exp[bi*DW +: DW]);
      exp_dqs = ~exp_dqs;
      chk("dqs", bus.mem_dqs_out, exp_dqs);
      wbuf[bi*DW +: DW] = bus.mem_dq_out;
      if (bi == BURST - 1) begin
        dram[wr_addr] = wbuf;
        wr_act = 1'b0;
      end
    end
    in_r = rd_act && cyc >= rd_start && cyc < rd_start + BURST;
    bus.mem_dq_in = in_r ? rd_mem[(cyc - rd_start)*DW +: DW]
                         : {$urandom, $urandom};
    in_p = rd_act && cyc == rd_due;
    if (bus.rsp_valid || in_p) begin
      chk("rsp_valid", bus.rsp_valid, in_p);
      if (bus.rsp_valid && in_p) begin
        chk("rsp_addr", bus.rsp_addr, rd_addr);
        chk("rsp_data", bus.rsp_rdata, rd_exp);
        rd_act = 1'b0;
      end
    end
    chk("level", bus.fifo_level, n_acc - n_cmd);
    chk("ready", bus.req_ready, (n_acc - n_cmd) < DEPTH);
    if (bus.req_valid && bus.req_ready) begin
      e.we = bus.req_we; e.addr = bus.req_addr;
      e.acc = cyc;
      if (bus.req_we) begin
        e.data = bus.req_wdata;
        shadow[bus.req_addr] = bus.req_wdata;
      end else begin
        e.data = shadow.exists(bus.req_addr) ?
                 shadow[bus.req_addr] : dflt(bus.req_addr);
      end
      q.push_back(e);
      n_acc++;
    end
  end

  task automatic flush();
    q.delete();
    wr_act = 1'b0; rd_act = 1'b0; exp_dqs = 1'b0;
    n_acc = 0; n_cmd = 0;
    shadow = dram;
    min_next = BOOT + 2;
  endtask

  task automatic reset_chk();
    chk("r_ready", bus.req_ready, 0);
    chk("r_boot", bus.boot_done, 0);
    chk("r_level", bus.fifo_level, 0);
    chk("r_cmdv", bus.mem_cmd_valid, 0);
    chk("r_cmdwe", bus.mem_cmd_we, 0);
    chk("r_cmda", bus.mem_cmd_addr, 0);
    chk("r_dq", bus.mem_dq_out, 0);
    chk("r_oe", bus.mem_dq_oe, 0);
    chk("r_dqs", bus.mem_dqs_out, 0);
    chk("r_rspv", bus.rsp_valid, 0);
    chk("r_rspa", bus.rsp_addr, 0);
    chk("r_rspd", bus.rsp_rdata, 0);
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a,
                      input logic [BW-1:0] d);
    int t;
    logic ok;
    t = 0;
    ok = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = we;
    bus.req_addr = a; bus.req_wdata = d;
    while (!ok && t < 300) begin
      @(negedge clk);
      ok = bus.req_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!ok) chk("send_timeout", 1'b0, 1'b1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || wr_act || rd_act) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", q.size() == 0 && !wr_act && !rd_act, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    logic got;
    logic [BW-1:0] d;
    logic [AW-1:0] a;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_dq_in = '0;
    dram[32'h200] = {64'h22, 64'h11};
    flush();
    repeat (3) @(posedge clk);
    #1 reset_chk();
    release_rst();
    repeat (2) @(posedge clk);
    #1;
    send(1'b1, 32'h100, {64'hB, 64'hA});
    send(1'b0, 32'h200, '0);
    drain();
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(1'b1, 32'h400, d);
      send(1'b0, 32'h400, '0);
    end
    drain();
    for (int i = 0; i < 40; i++) begin
      a = 32'h300 + 32'($urandom_range(0, 3)) * 32'h10;
      d = {$urandom, $urandom, $urandom, $urandom};
      send(1'($urandom_range(0, 1)), a, d);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();
    send(1'b0, 32'h200, '0);
    t = 0;
    got = 1'b0;
    while (!got && t < 200) begin
      @(negedge clk);
      got = bus.mem_cmd_valid && !bus.mem_cmd_we;
      t++;
    end
    chk("rd_cmd_seen", got, 1'b1);
    repeat (RDL) @(posedge clk);
    #2 rst = 1'b0;
    #1 reset_chk();
    flush();
    repeat (3) @(posedge clk);
    release_rst();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++)
      send(1'b1, 32'h500 + 32'(i) * 32'h10,
           {$urandom, $urandom, $urandom, $urandom});
    @(negedge clk);
    chk("fill_level", bus.fifo_level, DEPTH);
    chk("fill_ready", bus.req_ready, 1'b0);
    @(posedge clk); #1;
    send(1'b0, 32'h500, '0);
    drain();
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
